// File: rtl/apb_periph_demux_tmo.sv
// APB 1-to-NUM_SLV demultiplexer with base/mask decode, registered downstream request,
// per-transfer watchdog that answers a hung slave with PSLVERR, and error logging.
module apb_periph_demux_tmo #(
  parameter int NUM_SLV    = 8,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TMO_CYCLES = 255,
  parameter int CNT_W      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_SLV*ADDR_W-1:0] cfg_base_i,
  input  logic [NUM_SLV*ADDR_W-1:0] cfg_mask_i,
  input  logic [ADDR_W-1:0]         s_paddr_i,
  input  logic                      s_psel_i,
  input  logic                      s_penable_i,
  input  logic                      s_pwrite_i,
  input  logic [DATA_W-1:0]         s_pwdata_i,
  output logic [DATA_W-1:0]         s_prdata_o,
  output logic                      s_pready_o,
  output logic                      s_pslverr_o,
  output logic [NUM_SLV-1:0]        m_psel_o,
  output logic                      m_penable_o,
  output logic [ADDR_W-1:0]         m_paddr_o,
  output logic                      m_pwrite_o,
  output logic [DATA_W-1:0]         m_pwdata_o,
  input  logic [NUM_SLV*DATA_W-1:0] m_prdata_i,
  input  logic [NUM_SLV-1:0]        m_pready_i,
  input  logic [NUM_SLV-1:0]        m_pslverr_i,
  output logic                      tmo_o,
  output logic                      decerr_o,
  output logic [ADDR_W-1:0]         err_addr_o,
  output logic [CNT_W-1:0]          err_cnt_o,
  input  logic                      err_clr_i
);

  localparam int TMO_W = (TMO_CYCLES < 2) ? 1 : $clog2(TMO_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_SLV-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                slverr_q, slverr_d;
  logic [TMO_W-1:0]    wdog_q, wdog_d;
  logic                tmo_q, tmo_d;
  logic                decerr_q, decerr_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

  logic [NUM_SLV-1:0]  hit_oh;
  logic                sel_ready;
  logic                sel_slverr;
  logic [DATA_W-1:0]   sel_rdata;
  logic                wdog_hit;

  // Walk downwards so the lowest matching slave is the last one written.
  always_comb begin
    hit_oh = '0;
    for (int k = NUM_SLV - 1; k >= 0; k--) begin
      if ((s_paddr_i & cfg_mask_i[k*ADDR_W +: ADDR_W]) ==
          (cfg_base_i[k*ADDR_W +: ADDR_W] & cfg_mask_i[k*ADDR_W +: ADDR_W])) begin
        hit_oh    = '0;
        hit_oh[k] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_ready  = |(m_pready_i & sel_q);
    sel_slverr = |(m_pslverr_i & sel_q);
    sel_rdata  = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (sel_q[k]) sel_rdata = sel_rdata | m_prdata_i[k*DATA_W +: DATA_W];
    end
  end

  assign wdog_hit = (TMO_CYCLES != 0) && (wdog_q == TMO_W'(TMO_CYCLES - 1));

  // NOTE: every *_d gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    rdata_d    = rdata_q;
    slverr_d   = slverr_q;
    wdog_d     = wdog_q;
    tmo_d      = 1'b0;
    decerr_d   = 1'b0;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (s_psel_i && !s_penable_i) begin
          addr_d  = s_paddr_i;
          wdata_d = s_pwdata_i;
          write_d = s_pwrite_i;
          sel_d   = hit_oh;
          if (|hit_oh) begin
            state_d = S_SETUP;
          end else begin
            state_d  = S_ERR;
            decerr_d = 1'b1;
          end
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (sel_ready) begin
          rdata_d  = sel_rdata;
          slverr_d = sel_slverr;
          state_d  = S_RESP;
        end else if (wdog_hit) begin
          rdata_d  = '0;
          slverr_d = 1'b1;
          tmo_d    = 1'b1;
          state_d  = S_RESP;
        end else if (TMO_CYCLES != 0) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_RESP: begin
        wdog_d  = '0;
        state_d = S_IDLE;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (tmo_d || decerr_d) begin
      err_addr_d = tmo_d ? addr_q : s_paddr_i;
    end

    // A clear coinciding with a new error leaves exactly that error counted.
    if (err_clr_i) begin
      err_cnt_d = (tmo_d || decerr_d) ? CNT_W'(1) : '0;
    end else if ((tmo_d || decerr_d) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments; the datapath is reset too so every output is 0 after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      rdata_q    <= '0;
      slverr_q   <= 1'b0;
      wdog_q     <= '0;
      tmo_q      <= 1'b0;
      decerr_q   <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      rdata_q    <= rdata_d;
      slverr_q   <= slverr_d;
      wdog_q     <= wdog_d;
      tmo_q      <= tmo_d;
      decerr_q   <= decerr_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  logic resp_phase;
  assign resp_phase  = (state_q == S_RESP) || (state_q == S_ERR);

  // The response is gated by s_psel_i so an abandoned transfer completes silently.
  assign s_pready_o  = s_psel_i && resp_phase;
  assign s_pslverr_o = s_pready_o && ((state_q == S_ERR) || slverr_q);
  assign s_prdata_o  = (s_pready_o && (state_q == S_RESP)) ? rdata_q : '0;

  assign m_psel_o    = ((state_q == S_SETUP) || (state_q == S_ACCESS)) ? sel_q : '0;
  assign m_penable_o = (state_q == S_ACCESS);
  assign m_paddr_o   = addr_q;
  assign m_pwrite_o  = write_q;
  assign m_pwdata_o  = wdata_q;

  assign tmo_o       = tmo_q;
  assign decerr_o    = decerr_q;
  assign err_addr_o  = err_addr_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_apb_periph_demux_tmo.sv
// Directed table-driven bench for apb_periph_demux_tmo with a behavioural slave model.
module tb_apb_periph_demux_tmo;

  localparam int NS = 8;
  localparam int AW = 32;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NS*AW-1:0] cfg_base, cfg_mask;
  logic [AW-1:0]    s_paddr = '0;
  logic             s_psel = 1'b0, s_penable = 1'b0, s_pwrite = 1'b0;
  logic [DW-1:0]    s_pwdata = '0;
  logic [DW-1:0]    s_prdata;
  logic             s_pready, s_pslverr;
  logic [NS-1:0]    m_psel;
  logic             m_penable, m_pwrite;
  logic [AW-1:0]    m_paddr;
  logic [DW-1:0]    m_pwdata;
  logic [NS*DW-1:0] m_prdata;
  logic [NS-1:0]    m_pready, m_pslverr;
  logic             tmo, decerr;
  logic [AW-1:0]    err_addr;
  logic [1:0]       err_cnt;
  logic             err_clr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  apb_periph_demux_tmo #(
    .NUM_SLV(NS), .ADDR_W(AW), .DATA_W(DW), .TMO_CYCLES(16), .CNT_W(2)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_base_i(cfg_base), .cfg_mask_i(cfg_mask),
    .s_paddr_i(s_paddr), .s_psel_i(s_psel), .s_penable_i(s_penable),
    .s_pwrite_i(s_pwrite), .s_pwdata_i(s_pwdata),
    .s_prdata_o(s_prdata), .s_pready_o(s_pready), .s_pslverr_o(s_pslverr),
    .m_psel_o(m_psel), .m_penable_o(m_penable), .m_paddr_o(m_paddr),
    .m_pwrite_o(m_pwrite), .m_pwdata_o(m_pwdata),
    .m_prdata_i(m_prdata), .m_pready_i(m_pready), .m_pslverr_i(m_pslverr),
    .tmo_o(tmo), .decerr_o(decerr), .err_addr_o(err_addr), .err_cnt_o(err_cnt),
    .err_clr_i(err_clr)
  );

  // Slave model: ready after slv_wait ACCESS cycles, never if dead; read data only on reads.
  int          slv_wait [NS];
  logic        slv_dead [NS];
  logic        slv_err  [NS];
  logic [31:0] slv_rdata[NS];
  int          acc_cnt = 0;

  always @(posedge clk) acc_cnt <= m_penable ? acc_cnt + 1 : 0;

  always_comb begin
    m_pready  = '0;
    m_pslverr = '0;
    m_prdata  = '0;
    for (int k = 0; k < NS; k++) begin
      m_pready[k]  = m_psel[k] & m_penable & !slv_dead[k] & (acc_cnt >= slv_wait[k]);
      m_pslverr[k] = m_psel[k] & m_penable & slv_err[k];
      if (!m_pwrite) m_prdata[k*DW +: DW] = slv_rdata[k];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [7:0]  exp_sel;
    int          exp_lat;
    int          exp_acc;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_dec;
    logic        exp_tmo;
    logic [1:0]  exp_cnt;
  } vec_t;

  typedef struct {
    int          lat;
    int          acc;
    logic [7:0]  sel_t1;
    logic        pen_t1;
    logic        stable;
    logic [31:0] rdata;
    logic        slverr;
    logic        tmo;
    logic        dec;
    logic [1:0]  cnt;
    logic [31:0] eaddr;
  } res_t;

  // Starts #1 after a rising edge; cycle T is the upstream SETUP cycle, lat counts from T.
  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic clr, output res_t r);
    bit done = 0;
    r = '{default: '0};
    r.stable = 1'b1;
    s_paddr = addr; s_pwrite = wr; s_pwdata = wdata;
    s_psel = 1'b1; s_penable = 1'b0; err_clr = clr;
    @(posedge clk); #1;
    s_penable = 1'b1; err_clr = 1'b0;
    while (!done) begin
      r.lat++;
      @(negedge clk);
      if (r.lat == 1) begin
        r.sel_t1 = m_psel;
        r.pen_t1 = m_penable;
      end
      if (m_penable) r.acc++;
      if (m_psel != '0 && (m_pwdata != wdata || m_paddr != addr || m_pwrite != wr)) r.stable = 1'b0;
      if (s_pready) begin
        r.rdata = s_prdata; r.slverr = s_pslverr;
        r.tmo = tmo; r.dec = decerr; r.cnt = err_cnt; r.eaddr = err_addr;
        done = 1;
      end else if (r.lat >= 64) begin
        done = 1;
      end
      @(posedge clk); #1;
    end
    s_psel = 1'b0; s_penable = 1'b0;
  endtask

  vec_t vecs[10];
  res_t r;

  initial begin
    logic [31:0] bases[NS];
    logic [31:0] masks[NS];
    bases = '{32'h4000_0000, 32'h3000_0000, 32'h1A10_2000, 32'h3010_0000,
              32'h5000_0000, 32'h6000_0000, 32'h7000_0000, 32'h8000_0000};
    masks = '{32'hFFFF_0000, 32'hFF00_0000, 32'hFFFF_F000, 32'hFFF0_0000,
              32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};
    for (int k = 0; k < NS; k++) begin
      cfg_base[k*AW +: AW] = bases[k];
      cfg_mask[k*AW +: AW] = masks[k];
      slv_wait[k]  = 0;
      slv_dead[k]  = 1'b0;
      slv_err[k]   = 1'b0;
      slv_rdata[k] = 32'hA5A5_0000 | 32'(k);
    end
    slv_rdata[2] = 32'hCAFE_F00D;
    slv_wait[5]  = 3;
    slv_err[5]   = 1'b1;
    slv_dead[6]  = 1'b1;

    //          addr          wr    wdata         sel    lat acc rdata         err   dec   tmo   cnt
    vecs[0] = '{32'h1A10_2010, 1'b0, 32'h0,        8'h04, 3,  1,  32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[1] = '{32'h6000_0040, 1'b1, 32'h1234_5678, 8'h20, 6,  4,  32'h0,        1'b1, 1'b0, 1'b0, 2'd0};
    vecs[2] = '{32'hDEAD_0000, 1'b0, 32'h0,        8'h00, 1,  0,  32'h0,        1'b1, 1'b1, 1'b0, 2'd1};
    vecs[3] = '{32'h3010_0004, 1'b0, 32'h0,        8'h02, 3,  1,  32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[4] = '{32'h4000_1234, 1'b0, 32'h0,        8'h01, 3,  1,  32'hA5A5_0000, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[5] = '{32'h8000_0000, 1'b1, 32'hFFFF_0000, 8'h80, 3,  1,  32'h0,        1'b0, 1'b0, 1'b0, 2'd1};
    vecs[6] = '{32'h7000_0010, 1'b0, 32'h0,        8'h40, 18, 16, 32'h0,        1'b1, 1'b0, 1'b1, 2'd2};
    vecs[7] = '{32'h1A10_2FFC, 1'b0, 32'h0,        8'h04, 3,  1,  32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 2'd2};
    vecs[8] = '{32'h1A10_3000, 1'b0, 32'h0,        8'h00, 1,  0,  32'h0,        1'b1, 1'b1, 1'b0, 2'd3};
    vecs[9] = '{32'h5000_FFFF, 1'b0, 32'h0,        8'h10, 3,  1,  32'hA5A5_0004, 1'b0, 1'b0, 1'b0, 2'd3};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset m_psel",    m_psel, 0);
    check("reset m_penable", m_penable, 0);
    check("reset s_pready",  s_pready, 0);
    check("reset err_cnt",   err_cnt, 0);
    check("reset m_paddr",   m_paddr, 0);
    check("reset pulses",    {tmo, decerr}, 0);
    @(posedge clk); #1;

    // Consecutive calls also exercise back-to-back acceptance in the IDLE cycle after RESP/ERR.
    for (int i = 0; i < 10; i++) begin
      apb_xfer(vecs[i].addr, vecs[i].wr, vecs[i].wdata, 1'b0, r);
      check($sformatf("v%0d latency", i),   r.lat,    vecs[i].exp_lat);
      check($sformatf("v%0d psel T+1", i),  r.sel_t1, vecs[i].exp_sel);
      check($sformatf("v%0d penable T+1", i), r.pen_t1, 0);
      check($sformatf("v%0d access cyc", i), r.acc,   vecs[i].exp_acc);
      check($sformatf("v%0d stable", i),    r.stable, 1);
      check($sformatf("v%0d prdata", i),    r.rdata,  vecs[i].exp_rdata);
      check($sformatf("v%0d pslverr", i),   r.slverr, vecs[i].exp_err);
      check($sformatf("v%0d decerr", i),    r.dec,    vecs[i].exp_dec);
      check($sformatf("v%0d tmo", i),       r.tmo,    vecs[i].exp_tmo);
      check($sformatf("v%0d err_cnt", i),   r.cnt,    vecs[i].exp_cnt);
      if (vecs[i].exp_dec || vecs[i].exp_tmo)
        check($sformatf("v%0d err_addr", i), r.eaddr, vecs[i].addr);
    end

    // Fourth error with a 2-bit counter saturates at 3.
    apb_xfer(32'hDEAD_0000, 1'b0, 32'h0, 1'b0, r);
    check("sat decerr", r.dec, 1);
    check("sat err_cnt", r.cnt, 3);

    // Clear on an idle bus.
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("clr alone err_cnt", err_cnt, 0);
    @(posedge clk); #1;

    apb_xfer(32'hDEAD_0100, 1'b0, 32'h0, 1'b0, r);
    check("post-clr err_cnt", r.cnt, 1);
    apb_xfer(32'hDEAD_0200, 1'b0, 32'h0, 1'b1, r);
    check("clr+err err_cnt", r.cnt, 1);
    check("clr+err err_addr", r.eaddr, 32'hDEAD_0200);

    // Reset asserted while the wait-state slave is in ACCESS.
    s_paddr = 32'h6000_0000; s_pwrite = 1'b1; s_pwdata = 32'hAAAA_5555;
    s_psel = 1'b1; s_penable = 1'b0;
    @(posedge clk); #1;
    s_penable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst pre access penable", m_penable, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; s_psel = 1'b0; s_penable = 1'b0;
    @(negedge clk);
    check("rst mid m_psel",    m_psel, 0);
    check("rst mid m_penable", m_penable, 0);
    check("rst mid s_pready",  s_pready, 0);
    check("rst mid m_pwdata",  m_pwdata, 0);
    check("rst mid err_cnt",   err_cnt, 0);
    @(posedge clk); #1;

    apb_xfer(32'h1A10_2010, 1'b0, 32'h0, 1'b0, r);
    check("post-rst latency", r.lat, 3);
    check("post-rst prdata",  r.rdata, 32'hCAFE_F00D);
    check("post-rst pslverr", r.slverr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
